// File: rtl/shift_register_universal.sv
// Universal shift register: WIDTH-bit register with mode-selected
// hold/load/clear/shift/rotate ops and a multi-cycle "shift by amt" op
// driven by a start/busy/done handshake.
// Ports:
//   clk, rst          clock, async active-high reset
//   en                enables single-cycle ops and start acceptance
//   mode[2:0]         op select: HOLD LOAD SHL SHR ROL ROR ASR CLEAR
//   in[WIDTH-1:0]     parallel load data
//   ser_l / ser_r     serial fill bits for SHL / SHR
//   start, amt        request a multi-cycle shift of amt steps
//   out               register contents
//   ser_out_l/_r      MSB / LSB of out (combinational)
//   busy, done        multi-cycle op in progress / one-cycle completion pulse
module shift_register_universal #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             ser_l,
  input  logic             ser_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One step of the selected operation applied to the current value.
  function automatic logic [WIDTH-1:0] step_f(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      M_HOLD:  r = cur;
      M_LOAD:  r = ld;
      M_SHL:   r = {cur[WIDTH-2:0], sl};
      M_SHR:   r = {sr, cur[WIDTH-1:1]};
      M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
      M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLEAR: r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Only SHL..ASR can run as multi-cycle ops.
  function automatic logic is_shift_f(input logic [2:0] m);
    return (m >= M_SHL) && (m <= M_ASR);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          if (start && is_shift_f(mode)) begin
            if (amt == '0) begin
              // Zero-length shift: just acknowledge.
              done_d = 1'b1;
            end else begin
              // First step happens on the acceptance edge.
              out_d = step_f(mode, out_q, in, ser_l, ser_r);
              if (amt == AMT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                state_d = S_RUN;
                mode_d  = mode;
                cnt_d   = amt - AMT_W'(1);
              end
            end
          end else begin
            out_d = step_f(mode, out_q, in, ser_l, ser_r);
          end
        end
      end
      S_RUN: begin
        // cnt_q holds the number of steps still to apply.
        out_d = step_f(mode_q, out_q, in, ser_l, ser_r);
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ser_out_l = out_q[WIDTH-1];
  assign ser_out_r = out_q[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Scoreboard bench for shift_register_universal (WIDTH=8, AMT_W=4).
// Stimulus pushes the expected post-edge state; a monitor pops and compares.
module tb_shift_register_universal;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  in;
  logic          ser_l, ser_r, start;
  logic [AW-1:0] amt;
  logic [W-1:0]  out;
  logic          ser_out_l, ser_out_r, busy, done;

  shift_register_universal #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in),
    .ser_l(ser_l), .ser_r(ser_r), .start(start), .amt(amt),
    .out(out), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int   m_out;
  bit   m_busy;
  int   m_left;
  int   m_mode;

  function automatic void check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Single step computed with plain arithmetic on the integer value.
  function automatic int ref_step(int m, int x, int d, int sl, int sr);
    int p = 1 << W;
    int h = 1 << (W - 1);
    case (m)
      0: return x;
      1: return d;
      2: return (x * 2 + sl) % p;
      3: return x / 2 + sr * h;
      4: return (x * 2) % p + x / h;
      5: return x / 2 + (x % 2) * h;
      6: return x / 2 + ((x >= h) ? h : 0);
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_out = 0; m_busy = 0; m_left = 0; m_mode = 0;
  endfunction

  // Advance model by one clock edge; returns done flag for that edge.
  function automatic bit model_edge(bit e, int m, int d, bit s, int a, bit sl, bit sr);
    bit dn = 0;
    if (m_busy) begin
      m_out = ref_step(m_mode, m_out, d, sl, sr);
      m_left--;
      if (m_left == 0) begin m_busy = 0; dn = 1; end
    end else if (e) begin
      if (s && m >= 2 && m <= 6) begin
        if (a == 0) dn = 1;
        else begin
          m_out = ref_step(m, m_out, d, sl, sr);
          if (a == 1) dn = 1;
          else begin m_busy = 1; m_left = a - 1; m_mode = m; end
        end
      end else begin
        m_out = ref_step(m, m_out, d, sl, sr);
      end
    end
    return dn;
  endfunction

  task automatic drive(bit e, bit [2:0] m, bit [W-1:0] d, bit s, bit [AW-1:0] a,
                       bit sl, bit sr);
    exp_t x;
    bit   dn;
    @(negedge clk);
    en = e; mode = m; in = d; start = s; amt = a; ser_l = sl; ser_r = sr;
    dn = model_edge(e, int'(m), int'(d), s, int'(a), sl, sr);
    x.out = W'(m_out); x.busy = m_busy; x.done = dn;
    exp_q.push_back(x);
  endtask

  task automatic idle(bit sl = 0, bit sr = 0);
    drive(1'b0, 3'b000, 8'h00, 1'b0, 4'd0, sl, sr);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every post-edge output against the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("out", int'(out), int'(x.out));
        check("busy", int'(busy), int'(x.busy));
        check("done", int'(done), int'(x.done));
        check("ser_out_l", int'(ser_out_l), int'(x.out[W-1]));
        check("ser_out_r", int'(ser_out_r), int'(x.out[0]));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 0; mode = 0; in = 0; ser_l = 0; ser_r = 0; start = 0; amt = 0;
    model_reset();
    #12;
    check("reset_out", int'(out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Load, then disabled CLEAR must not change out
    drive(1, 3'b001, 8'hA5, 0, 0, 0, 0);
    drive(0, 3'b111, 8'h00, 1, 4'd3, 0, 0);
    settle();
    check("en0_hold", int'(out), 'hA5);

    // ROL by 3 from 81
    drive(1, 3'b001, 8'h81, 0, 0, 0, 0);
    drive(1, 3'b100, 8'h00, 1, 4'd3, 0, 0);
    idle();
    idle();
    settle();
    check("rol3_out", int'(out), 'h0C);
    check("rol3_done", int'(done), 1);
    check("rol3_busy", int'(busy), 0);
    idle();

    // ASR by 9 saturates to sign
    drive(1, 3'b001, 8'h80, 0, 0, 0, 0);
    drive(1, 3'b110, 8'h00, 1, 4'd9, 0, 0);
    repeat (8) idle();
    settle();
    check("asr9_out", int'(out), 'hFF);

    // SHR by 2 filling with ones
    drive(1, 3'b001, 8'h00, 0, 0, 0, 0);
    drive(1, 3'b011, 8'h00, 1, 4'd2, 0, 1);
    idle(0, 1);
    settle();
    check("shr2_out", int'(out), 'hC0);

    // amt=0 shift: done only
    drive(1, 3'b010, 8'h00, 1, 4'd0, 1, 0);
    settle();
    check("amt0_out", int'(out), 'hC0);
    check("amt0_done", int'(done), 1);
    check("amt0_busy", int'(busy), 0);

    // Inputs ignored during RUN; restart accepted in done cycle
    drive(1, 3'b001, 8'h3C, 0, 0, 0, 0);
    drive(1, 3'b010, 8'h00, 1, 4'd4, 1, 0);
    drive(1, 3'b001, 8'h00, 1, 4'd2, 0, 0);
    drive(1, 3'b111, 8'h00, 1, 4'd7, 1, 0);
    drive(1, 3'b001, 8'h00, 1, 4'd1, 0, 0);
    drive(1, 3'b101, 8'h00, 1, 4'd2, 0, 0);
    idle();
    idle();

    // Reset in the middle of an SHL by 5
    drive(1, 3'b001, 8'hFF, 0, 0, 0, 0);
    drive(1, 3'b010, 8'h00, 1, 4'd5, 0, 0);
    idle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_out", int'(out), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_done", int'(done), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 3'($urandom), 8'($urandom), ($urandom % 3) == 0,
            4'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (16) idle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
